mem_stage: RTL

//  Pipeline stage directly downstream of the execute stage. Registers the EX results
//  (dest reg, write-enable, ALU result, store operand). Runs LW/SW through a req/ack

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_dbus_ctrl.sv | 83 ++++++++
 rtl/mem_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: mem-op codes, exception codes,
// bus FSM states and the alignment helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEMOP_NONE = 2'b00,
    MEMOP_LW   = 2'b01,
    MEMOP_SW   = 2'b10,
    MEMOP_RSV  = 2'b11
  } memop_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADDR = 2'b01,
    EXC_BUS  = 2'b10,
    EXC_RSV  = 2'b11
  } exc_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dbus_state_t;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_dbus_ctrl.sv
// Data-bus controller: IDLE/BUSY FSM, req/ack handshake and timeout counter.
// Reports completion (done) or timeout (abort) as strobes valid in the last
// BUSY cycle, so the parent can register its writeback on the same edge.
module dbus_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_ack,
  output logic        o_req,
  output logic        o_we,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  dbus_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             w_busy;
  logic             w_last;

  assign w_busy  = (r_state == ST_BUSY);
  assign w_last  = (r_cnt == LP_CNT_LAST);
  assign o_busy  = w_busy;
  // Ack beats timeout when both land in the final BUSY cycle.
  assign o_done  = w_busy & i_ack;
  assign o_abort = w_busy & ~i_ack & w_last;

  assign o_req   = r_req;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

  // Bus FSM: launch on start, finish on ack or when the wait budget runs out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_BUSY;
            r_req   <= 1'b1;
            r_cnt   <= '0;
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
          end
        end
        ST_BUSY: begin
          if (i_ack || w_last) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers EX results, runs LW/SW through dbus_ctrl,
// stalls EX while an access is outstanding and emits one writeback record
// per instruction, flagging misaligned addresses and bus timeouts.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_memop_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [31:0] ex_reg2_i,
  output logic        stall_req_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        valid_o,
  output logic [4:0]  waddr_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [1:0]  exc_o
);

  memop_t      w_memop;
  logic        w_is_mem;
  logic        w_aligned;
  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic        w_abort;

  logic        r_valid;
  logic [4:0]  r_waddr;
  logic        r_wreg;
  logic [31:0] r_wdata;
  exc_t        r_exc;
  logic [4:0]  r_lat_waddr;
  logic        r_lat_wreg;
  logic        r_lat_lw;

  assign w_memop   = memop_t'(ex_memop_i);
  assign w_is_mem  = (w_memop == MEMOP_LW) || (w_memop == MEMOP_SW);
  assign w_aligned = is_aligned(ex_wdata_i);
  assign w_start   = ~w_busy & ex_valid_i & w_is_mem & w_aligned;

  dbus_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dbus_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_we    (w_memop == MEMOP_SW),
    .i_addr  (ex_wdata_i),
    .i_wdata (ex_reg2_i),
    .i_ack   (dbus_ack_i),
    .o_req   (dbus_req_o),
    .o_we    (dbus_we_o),
    .o_addr  (dbus_addr_o),
    .o_wdata (dbus_wdata_o),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_abort (w_abort)
  );

  assign stall_req_o = w_busy;
  assign valid_o     = r_valid;
  assign waddr_o     = r_waddr;
  assign wreg_o      = r_wreg;
  assign wdata_o     = r_wdata;
  assign exc_o       = r_exc;

  // Writeback record: pass-through when idle, bus result or exception otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_waddr     <= '0;
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_exc       <= EXC_NONE;
      r_lat_waddr <= '0;
      r_lat_wreg  <= 1'b0;
      r_lat_lw    <= 1'b0;
    end else if (!w_busy) begin
      if (!ex_valid_i) begin
        r_valid <= 1'b0;
      end else if (w_is_mem) begin
        if (!w_aligned) begin
          r_valid <= 1'b1;
          r_waddr <= ex_waddr_i;
          r_wreg  <= 1'b0;
          r_wdata <= '0;
          r_exc   <= EXC_ADDR;
        end else begin
          r_valid     <= 1'b0;
          r_lat_waddr <= ex_waddr_i;
          r_lat_wreg  <= ex_wreg_i;
          r_lat_lw    <= (w_memop == MEMOP_LW);
        end
      end else begin
        r_valid <= 1'b1;
        r_waddr <= ex_waddr_i;
        r_wreg  <= ex_wreg_i;
        r_wdata <= ex_wdata_i;
        r_exc   <= EXC_NONE;
      end
    end else if (w_done) begin
      r_valid <= 1'b1;
      r_waddr <= r_lat_waddr;
      r_wreg  <= r_lat_lw & r_lat_wreg;
      r_wdata <= r_lat_lw ? dbus_rdata_i : '0;
      r_exc   <= EXC_NONE;
    end else if (w_abort) begin
      r_valid <= 1'b1;
      r_waddr <= r_lat_waddr;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      r_exc   <= EXC_BUS;
    end else begin
      r_valid <= 1'b0;
    end
  end

endmodule
